mac_engine_nlane: RTL and testbench

- Parametrised next-generation MAC engine for the HWPE datapath: N_LANES independent signed multiply-accumulate lanes.
- Fed by two joined input streams (a, b) from the streamer; produces one output stream (d).
- Two modes:
  - product mode: one output beat per input beat.
  - accumulate mode: one output beat per job of len_i beats.
- Controlled from the ctrl block via start/len/mode/shift; reports busy/done.

---
 rtl/mac_engine_nlane.sv | 217 +++++++++++++++++++++
 tb/tb_mac_engine_nlane.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_engine_nlane.sv
// mac_engine_nlane: N_LANES independent signed multiply-accumulate lanes.
// A two-stage pipeline (sign-extended product register, shifted output
// register) is fed by the joined a/b streams and drives the d stream.
// Product mode emits one beat per input beat. Accumulate mode emits one
// beat per job.
// Build option: define MAC_SATURATE_EN to saturate the shifted result to the
// signed OUT_W range. Without it the result is truncated to the low OUT_W bits.
module mac_engine_nlane #(
    parameter int N_LANES = 4,
    parameter int DW      = 32,
    parameter int ACC_W   = 64,
    parameter int OUT_W   = 32,
    parameter int LEN_W   = 16,
    localparam int SH_W   = $clog2(ACC_W)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     start_i,
    input  logic [LEN_W-1:0]         len_i,
    input  logic                     mode_i,
    input  logic [SH_W-1:0]          shift_i,
    input  logic                     a_valid_i,
    output logic                     a_ready_o,
    input  logic [N_LANES*DW-1:0]    a_data_i,
    input  logic                     b_valid_i,
    output logic                     b_ready_o,
    input  logic [N_LANES*DW-1:0]    b_data_i,
    output logic                     d_valid_o,
    input  logic                     d_ready_i,
    output logic [N_LANES*OUT_W-1:0] d_data_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
`endif

    state_t                   r_state;
    state_t                   w_state_next;
    logic [LEN_W-1:0]         r_len;
    logic [LEN_W-1:0]         r_cnt;
    logic                     r_mode;
    logic [SH_W-1:0]          r_shift;
    logic                     r_s1_valid;
    logic                     r_s1_last;
    logic signed [ACC_W-1:0]  r_s1_prod [N_LANES];
    logic signed [ACC_W-1:0]  r_acc     [N_LANES];
    logic                     r_s2_valid;
    logic [N_LANES*OUT_W-1:0] r_s2_data;

    logic signed [ACC_W-1:0]  w_prod    [N_LANES];
    logic signed [ACC_W-1:0]  w_acc_sum [N_LANES];
    logic [N_LANES*OUT_W-1:0] w_s2_next;
    logic w_s2_free, w_s1_emit, w_s1_adv, w_s2_load;
    logic w_in_ready, w_accept, w_last_beat, w_start, w_drain_done;

    // Arithmetic right shift followed by truncation or saturation to OUT_W.
    function automatic logic [OUT_W-1:0] shapeOut(input logic signed [ACC_W-1:0] value,
                                                  input logic [SH_W-1:0] sh);
        logic signed [ACC_W-1:0] shifted;
        shifted = value >>> sh;
`ifdef MAC_SATURATE_EN
        if (shifted > SAT_MAX) begin
            return SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            return SAT_MIN[OUT_W-1:0];
        end
`endif
        return shifted[OUT_W-1:0];
    endfunction

    // Stage 1 drains into the accumulator (non-final accumulate beats) or into stage 2.
    assign w_s2_free    = !r_s2_valid || d_ready_i;
    assign w_s1_emit    = !r_mode || r_s1_last;
    assign w_s1_adv     = r_s1_valid && (!w_s1_emit || w_s2_free);
    assign w_s2_load    = r_s1_valid && w_s1_emit && w_s2_free;
    assign w_in_ready   = (r_state == RUN) && (!r_s1_valid || w_s1_adv);
    assign w_accept     = w_in_ready && a_valid_i && b_valid_i;
    assign w_last_beat  = (r_cnt == r_len - LEN_W'(1));
    assign w_start      = (r_state == IDLE) && start_i && !clear_i;
    assign w_drain_done = !r_s1_valid && (!r_s2_valid || d_ready_i);

    assign a_ready_o = w_in_ready;
    assign b_ready_o = w_in_ready;
    assign d_valid_o = r_s2_valid;
    assign d_data_o  = r_s2_data;

    // Per-lane sign-extended products, accumulator sums and shaped stage-2 data.
    always_comb begin
        w_s2_next = '0;
        for (int k = 0; k < N_LANES; k++) begin
            w_prod[k] = $signed({{(ACC_W-DW){a_data_i[k*DW+DW-1]}}, a_data_i[k*DW +: DW]})
                      * $signed({{(ACC_W-DW){b_data_i[k*DW+DW-1]}}, b_data_i[k*DW +: DW]});
            w_acc_sum[k] = r_acc[k] + r_s1_prod[k];
            w_s2_next[k*OUT_W +: OUT_W] = shapeOut(r_mode ? w_acc_sum[k] : r_s1_prod[k], r_shift);
        end
    end

    // Next-state and status outputs. Soft clear overrides everything else.
    always_comb begin
        w_state_next = r_state;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_next = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (w_accept && w_last_beat) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy_o = 1'b1;
                if (w_drain_done) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done_o       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
        if (clear_i) begin
            w_state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Job parameters latched at start; beat counter stepped on every accepted beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_mode  <= 1'b0;
            r_shift <= '0;
        end else if (w_start) begin
            r_len   <= len_i;
            r_cnt   <= '0;
            r_mode  <= mode_i;
            r_shift <= shift_i;
        end else if (w_accept) begin
            r_cnt <= r_cnt + LEN_W'(1);
        end
    end

    // Stage 1: capture products of each accepted beat and flag the job's last beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            for (int k = 0; k < N_LANES; k++) begin
                r_s1_prod[k] <= '0;
            end
        end else if (clear_i) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_last  <= w_last_beat;
            for (int k = 0; k < N_LANES; k++) begin
                r_s1_prod[k] <= w_prod[k];
            end
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Accumulators: zeroed at job start or clear, summed as stage 1 advances.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < N_LANES; k++) begin
                r_acc[k] <= '0;
            end
        end else if (clear_i || w_start) begin
            for (int k = 0; k < N_LANES; k++) begin
                r_acc[k] <= '0;
            end
        end else if (w_s1_adv && r_mode) begin
            for (int k = 0; k < N_LANES; k++) begin
                r_acc[k] <= w_acc_sum[k];
            end
        end
    end

    // Stage 2: output register, held stable until the consumer takes it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
        end else if (clear_i) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= 1'b1;
            r_s2_data  <= w_s2_next;
        end else if (d_ready_i) begin
            r_s2_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_engine_nlane.sv
// tb_mac_engine_nlane: randomized self-checking bench for mac_engine_nlane.
// Expected results come from a per-job arithmetic model over the beat tables.
module tb_mac_engine_nlane;

    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int OUT_W = 32;
    localparam int LEN_W = 16;
    localparam int SH_W  = 6;
    localparam int MAXB  = 64;

    logic               clk = 1'b0;
    logic               rstN = 1'b0;
    logic               clearI = 1'b0;
    logic               startI = 1'b0;
    logic [LEN_W-1:0]   lenI = '0;
    logic               modeI = 1'b0;
    logic [SH_W-1:0]    shiftI = '0;
    logic               aValid = 1'b0;
    logic               aReady;
    logic [N*DW-1:0]    aData = '0;
    logic               bValid = 1'b0;
    logic               bReady;
    logic [N*DW-1:0]    bData = '0;
    logic               dValid;
    logic               dReady = 1'b1;
    logic [N*OUT_W-1:0] dData;
    logic               busyO;
    logic               doneO;

    int nCompared   = 0;
    int nMismatched = 0;
    int jA [MAXB][N];
    int jB [MAXB][N];

    mac_engine_nlane dut (
        .clk_i     (clk),
        .rst_ni    (rstN),
        .clear_i   (clearI),
        .start_i   (startI),
        .len_i     (lenI),
        .mode_i    (modeI),
        .shift_i   (shiftI),
        .a_valid_i (aValid),
        .a_ready_o (aReady),
        .a_data_i  (aData),
        .b_valid_i (bValid),
        .b_ready_o (bReady),
        .b_data_i  (bData),
        .d_valid_o (dValid),
        .d_ready_i (dReady),
        .d_data_o  (dData),
        .busy_o    (busyO),
        .done_o    (doneO)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Hard stop if the run ever wedges.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] shapeRef(input longint value, input int sh);
        longint s;
        s = value >>> sh;
`ifdef MAC_SATURATE_EN
        if (s > 64'sd2147483647) return 32'h7FFFFFFF;
        if (s < -64'sd2147483648) return 32'h80000000;
`endif
        return s[31:0];
    endfunction

    function automatic logic [127:0] refProduct(input int i, input int sh);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            r[k*32 +: 32] = shapeRef(longint'(jA[i][k]) * longint'(jB[i][k]), sh);
        end
        return r;
    endfunction

    function automatic logic [127:0] refAccum(input int len, input int sh);
        logic [127:0] r;
        longint sum;
        r = '0;
        for (int k = 0; k < N; k++) begin
            sum = 0;
            for (int i = 0; i < len; i++) begin
                sum += longint'(jA[i][k]) * longint'(jB[i][k]);
            end
            r[k*32 +: 32] = shapeRef(sum, sh);
        end
        return r;
    endfunction

    function automatic int randVal();
        if ($urandom_range(0, 3) == 0) return int'($urandom);
        return int'($urandom_range(0, 400)) - 200;
    endfunction

    task automatic fillRandom(input int len);
        for (int i = 0; i < len; i++) begin
            for (int k = 0; k < N; k++) begin
                jA[i][k] = randVal();
                jB[i][k] = randVal();
            end
        end
    endtask

    task automatic fillConst(input int len, input int a0, input int a1, input int a2, input int a3,
                             input int b0, input int b1, input int b2, input int b3);
        for (int i = 0; i < len; i++) begin
            jA[i][0] = a0; jA[i][1] = a1; jA[i][2] = a2; jA[i][3] = a3;
            jB[i][0] = b0; jB[i][1] = b1; jB[i][2] = b2; jB[i][3] = b3;
        end
    endtask

    task automatic driveBeat(input int beat);
        for (int k = 0; k < N; k++) begin
            aData[k*32 +: 32] = jA[beat][k];
            bData[k*32 +: 32] = jB[beat][k];
        end
    endtask

    // Runs one job from the beat tables; rdyMode 0 = ready always, 1 = toggling, 2 = random.
    task automatic applyStimulus(input int len, input bit mode, input int sh, input int rdyMode,
                                 input bit gaps, input bit poke);
        logic [127:0] expQ[$];
        logic [127:0] held;
        bit stalled, accNow;
        int beat, cyc, doneCnt, doneCyc, outCnt, expCnt, firstAcc, lastAcc, firstOut, budget;
        expQ = {};
        if (len > 0) begin
            if (mode) expQ.push_back(refAccum(len, sh));
            else for (int i = 0; i < len; i++) expQ.push_back(refProduct(i, sh));
        end
        expCnt = expQ.size();
        beat = 0; cyc = 0; doneCnt = 0; doneCyc = -1; outCnt = 0;
        firstAcc = -1; lastAcc = -1; firstOut = -1; stalled = 0; held = '0;
        budget = 30 * len + 40;
        startI = 1'b1; lenI = LEN_W'(len); modeI = mode; shiftI = SH_W'(sh);
        aValid = 1'b0; bValid = 1'b0; dReady = 1'b1;
        @(posedge clk); #1;
        startI = 1'b0;
        while (cyc < budget && !(doneCnt > 0 && cyc > doneCyc + 2)) begin
            aValid = (beat < len) && (!gaps || $urandom_range(0, 3) != 0);
            bValid = (beat < len) && (!gaps || $urandom_range(0, 3) != 0);
            if (beat < len) driveBeat(beat);
            case (rdyMode)
                0:       dReady = 1'b1;
                1:       dReady = cyc[0];
                default: dReady = 1'($urandom_range(0, 1));
            endcase
            startI = poke && (cyc == 2);
            lenI   = startI ? LEN_W'(1) : LEN_W'(len);
            modeI  = startI ? !mode : mode;
            @(negedge clk);
            if (stalled) begin
                checkOutput("holdValid", dValid, 1'b1);
                checkOutput("holdData", dData, held);
            end
            stalled = 0;
            if (dValid) begin
                if (firstOut < 0) firstOut = cyc;
                if (dReady) begin
                    outCnt++;
                    if (expQ.size() == 0) checkOutput("outCount", outCnt, expCnt);
                    else checkOutput("data", dData, expQ.pop_front());
                end else begin
                    stalled = 1;
                    held = dData;
                end
            end
            if (!busyO) checkOutput("readyIdle", {aReady, bReady}, 2'b00);
            if (cyc == 0) checkOutput("busyStart", busyO, len > 0);
            accNow = aValid && bValid && aReady && bReady;
            if (doneO) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
                checkOutput("outsAtDone", outCnt, expCnt);
                checkOutput("busyAtDone", busyO, 1'b0);
            end
            @(posedge clk); #1;
            if (accNow) begin
                if (firstAcc < 0) firstAcc = cyc;
                lastAcc = cyc;
                beat++;
            end
            cyc++;
        end
        checkOutput("beatsTaken", beat, len);
        checkOutput("donePulses", doneCnt, 1);
        checkOutput("leftover", expQ.size(), 0);
        if (len == 0) checkOutput("zeroLenDone", doneCyc, 0);
        else checkOutput("latency", firstOut, mode ? lastAcc + 2 : firstAcc + 2);
        aValid = 1'b0; bValid = 1'b0; dReady = 1'b1; startI = 1'b0; modeI = mode;
    endtask

    // Soft clear after two beats of a five-beat accumulate job, with a colliding start.
    task automatic clearTest();
        int acc, cyc;
        bit accNow;
        acc = 0; cyc = 0;
        fillRandom(5);
        startI = 1'b1; lenI = LEN_W'(5); modeI = 1'b1; shiftI = '0; dReady = 1'b1;
        @(posedge clk); #1;
        startI = 1'b0;
        while (acc < 2 && cyc < 40) begin
            aValid = 1'b1; bValid = 1'b1;
            driveBeat(acc);
            @(negedge clk);
            accNow = aValid && bValid && aReady && bReady;
            @(posedge clk); #1;
            if (accNow) acc++;
            cyc++;
        end
        checkOutput("clearSetup", acc, 2);
        clearI = 1'b1; startI = 1'b1; lenI = LEN_W'(3);
        @(posedge clk); #1;
        clearI = 1'b0; startI = 1'b0; aValid = 1'b0; bValid = 1'b0;
        @(negedge clk);
        checkOutput("clearBusy", busyO, 1'b0);
        checkOutput("clearReady", aReady, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("clearNoValid", dValid, 1'b0);
            checkOutput("clearNoDone", doneO, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        fillConst(1, 2, 2, 2, 2, 3, 3, 3, 3);
        applyStimulus(1, 1'b1, 0, 0, 1'b0, 1'b0);
    endtask

    // Main sequence: reset, directed jobs, then randomized jobs.
    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstControl", {aReady, bReady, dValid, busyO, doneO}, 5'b0);
        checkOutput("rstData", dData, '0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("postRstControl", {aReady, bReady, dValid, busyO, doneO}, 5'b0);
        @(posedge clk); #1;

        $display("[TB] product mode, small signed operands");
        fillConst(3, 1, -2, 3, 4, 5, 6, -7, 8);
        applyStimulus(3, 1'b0, 0, 0, 1'b0, 1'b0);

        $display("[TB] accumulate mode, 0x7FFF squares with shift 2");
        fillConst(4, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF, 32'h7FFF);
        applyStimulus(4, 1'b1, 2, 0, 1'b0, 1'b0);

        $display("[TB] backpressure with toggling ready");
        fillRandom(8);
        applyStimulus(8, 1'b0, 0, 1, 1'b0, 1'b0);

        $display("[TB] zero-length job and ignored start during run");
        applyStimulus(0, 1'b0, 0, 0, 1'b0, 1'b0);
        fillRandom(6);
        applyStimulus(6, 1'b0, 3, 0, 1'b0, 1'b1);

        $display("[TB] soft clear mid-job");
        clearTest();

        $display("[TB] overflow of the largest positive product");
        fillConst(1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF,
                  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
        applyStimulus(1, 1'b0, 0, 0, 1'b0, 1'b0);

        $display("[TB] randomized jobs");
        for (int j = 0; j < 16; j++) begin
            int len, sh;
            bit mode;
            len  = $urandom_range(1, 20);
            mode = 1'($urandom_range(0, 1));
            sh   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 8);
            fillRandom(len);
            applyStimulus(len, mode, sh, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
                          (len >= 4) && ($urandom_range(0, 2) == 0));
            @(posedge clk); #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
